display_scan_ctrl: RTL and testbench



---
 rtl/display_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_display_scan_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with shadow/active code banks and frame-boundary commit.
// Optional LEADING_ZERO_BLANK_EN: darken leading 0x00 digits (digit 0 always shown).
module display_scan_ctrl #(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic                      wr_mode,
    input  logic [$clog2(DIGITS)-1:0] wr_index,
    input  logic [15:0]               wr_data,
    output logic [7:0]                seg_data,
    output logic                      seg_enable,
    output logic [DIGITS-1:0]         digit_sel,
    output logic                      frame_done
);
    localparam int IW      = $clog2(DIGITS);
    localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [7:0] DASH = 8'h10;

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     cur;
    logic [7:0]        shadow [DIGITS];
    logic [7:0]        active [DIGITS];
    logic              dirty;
    logic [DIGITS-1:0] suppress;
    logic [DIGITS-1:0] cur_onehot;
    logic              pre_commit;
    logic              wr_accept;

    assign cur_onehot = {{(DIGITS-1){1'b0}}, 1'b1} << cur;
    assign wr_accept  = wr_valid && wr_ready;
    // True in the cycle just before the last DRIVE cycle of the last digit.
    assign pre_commit = (state == DRIVE) && (cnt == CW'(PRESCALE - 2)) &&
                        (cur == IW'(DIGITS - 1));

`ifdef LEADING_ZERO_BLANK_EN
    logic zero_above;
    always_comb begin
        suppress   = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_above  = zero_above && (active[i] == 8'h00);
            suppress[i] = zero_above;
        end
    end
`else
    assign suppress = '0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= BLANK;
            cnt        <= '0;
            cur        <= '0;
            seg_data   <= 8'h00;
            seg_enable <= 1'b0;
            digit_sel  <= '1;
            wr_ready   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            wr_ready   <= !pre_commit;
            frame_done <= pre_commit;
            case (state)
                BLANK: begin
                    if (cnt == CW'(BLANK_CYCLES - 1)) begin
                        state      <= DRIVE;
                        cnt        <= '0;
                        seg_data   <= active[cur];
                        seg_enable <= !suppress[cur];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt == CW'(PRESCALE - 1)) begin
                        state      <= BLANK;
                        cnt        <= '0;
                        seg_enable <= 1'b0;
                        digit_sel  <= '1;
                        cur        <= (cur == IW'(DIGITS - 1)) ? '0 : cur + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        // Anode turns on one cycle after the decoder was fed, matching its register.
                        if (!suppress[cur]) digit_sel <= ~cur_onehot;
                    end
                end
                default: state <= BLANK;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                shadow[i] <= DASH;
                active[i] <= DASH;
            end
            dirty <= 1'b0;
        end else begin
            // wr_ready is low while frame_done is high, so commit and write never collide.
            if (frame_done && dirty) begin
                for (int i = 0; i < DIGITS; i++) active[i] <= shadow[i];
                dirty <= 1'b0;
            end
            if (wr_accept) begin
                if (!wr_mode) begin
                    if (int'(wr_index) < DIGITS) begin
                        shadow[wr_index] <= wr_data[7:0];
                        dirty            <= 1'b1;
                    end
                end else begin
                    for (int i = 0; i < DIGITS; i++)
                        shadow[i] <= (i < 4) ? {4'h0, wr_data[4*(i%4) +: 4]} : DASH;
                    dirty <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: 4-digit and 3-digit instances, PRESCALE=4, BLANK_CYCLES=1.
module tb_display_scan_ctrl;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        wr_valid;
    logic        wr_mode;
    logic [1:0]  wr_index;
    logic [15:0] wr_data;

    logic        wr_ready4, seg_enable4, frame_done4;
    logic [7:0]  seg_data4;
    logic [3:0]  digit_sel4;
    logic        wr_ready3, seg_enable3, frame_done3;
    logic [7:0]  seg_data3;
    logic [2:0]  digit_sel3;

    logic        use3;
    logic        wr_ready_m, seg_en_m, fd_m;
    logic [7:0]  seg_m;
    logic [3:0]  dsel_m;

    int          tests, fails;
    logic [31:0] cap_codes;
    logic [3:0]  cap_seen;
    int          cap_bad;

    localparam logic [31:0] DASHES = {4{8'h10}};
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] SEEN5 = 4'b0001;
    localparam logic [3:0] SEEN6 = 4'b0011;
`else
    localparam logic [3:0] SEEN5 = 4'b1111;
    localparam logic [3:0] SEEN6 = 4'b1111;
`endif

    typedef struct packed {
        logic        mode;
        logic [1:0]  idx;
        logic [15:0] data;
        logic [31:0] codes;   // digit i expected code at [8*i +: 8]
        logic [3:0]  seen;
    } vec_t;
    vec_t vecs [6];

    always #5 clock = ~clock;

    display_scan_ctrl #(.DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1)) dut4 (
        .clock(clock), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready4),
        .wr_mode(wr_mode), .wr_index(wr_index), .wr_data(wr_data), .seg_data(seg_data4),
        .seg_enable(seg_enable4), .digit_sel(digit_sel4), .frame_done(frame_done4)
    );

    display_scan_ctrl #(.DIGITS(3), .PRESCALE(4), .BLANK_CYCLES(1)) dut3 (
        .clock(clock), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready3),
        .wr_mode(wr_mode), .wr_index(wr_index), .wr_data(wr_data), .seg_data(seg_data3),
        .seg_enable(seg_enable3), .digit_sel(digit_sel3), .frame_done(frame_done3)
    );

    assign wr_ready_m = use3 ? wr_ready3 : wr_ready4;
    assign seg_en_m   = use3 ? seg_enable3 : seg_enable4;
    assign fd_m       = use3 ? frame_done3 : frame_done4;
    assign seg_m      = use3 ? seg_data3 : seg_data4;
    assign dsel_m     = use3 ? {1'b1, digit_sel3} : digit_sel4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_seg_data"},   {24'h0, seg_data4}, 32'h00);
        check({tag, "_seg_enable"}, {31'h0, seg_enable4}, 32'h0);
        check({tag, "_digit_sel"},  {28'h0, digit_sel4}, 32'hF);
        check({tag, "_wr_ready"},   {31'h0, wr_ready4}, 32'h0);
        check({tag, "_frame_done"}, {31'h0, frame_done4}, 32'h0);
    endtask

    // Samples every negedge until frame_done, recording the code shown on each lit digit.
    task automatic capture_frame();
        int   n;
        int   zeros;
        logic prev_en;
        cap_codes = '0;
        cap_seen  = '0;
        cap_bad   = 0;
        prev_en   = 1'b1;
        for (n = 0; n < 100; n++) begin
            @(negedge clock);
            if (dsel_m != 4'hF) begin
                zeros = 0;
                for (int d = 0; d < 4; d++) begin
                    if (!dsel_m[d]) begin
                        zeros++;
                        cap_seen[d]          = 1'b1;
                        cap_codes[8*d +: 8]  = seg_m;
                    end
                end
                if (zeros != 1 || !seg_en_m || !prev_en) cap_bad++;
            end
            prev_en = seg_en_m;
            if (fd_m) break;
        end
        check("frame_done_within_budget", {31'h0, (n < 100)}, 32'h1);
    endtask

    task automatic check_frame(input int row, input logic [31:0] codes,
                               input logic [3:0] seen, input int nd);
        for (int d = 0; d < nd; d++)
            if (seen[d])
                check($sformatf("row%0d_digit%0d_code", row, d),
                      {24'h0, cap_codes[8*d +: 8]}, {24'h0, codes[8*d +: 8]});
        check($sformatf("row%0d_lit_digits", row), {28'h0, cap_seen}, {28'h0, seen});
        check($sformatf("row%0d_alignment", row), cap_bad, 0);
    endtask

    task automatic check_partial(input int row, input logic [31:0] old_codes);
        for (int d = 0; d < 4; d++)
            if (cap_seen[d])
                check($sformatf("row%0d_precommit_digit%0d", row, d),
                      {24'h0, cap_codes[8*d +: 8]}, {24'h0, old_codes[8*d +: 8]});
        check($sformatf("row%0d_precommit_alignment", row), cap_bad, 0);
    endtask

    task automatic do_write(input logic mode, input logic [1:0] idx, input logic [15:0] data);
        int n = 0;
        @(negedge clock);
        wr_mode  = mode;
        wr_index = idx;
        wr_data  = data;
        wr_valid = 1'b1;
        while (!wr_ready_m && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("write_accepted", {31'h0, (n < 50)}, 32'h1);
        @(posedge clock);
        #1 wr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          first_fd, second_fd, sel0_low, n;
        logic [31:0] prev;

        vecs[0] = '{1'b1, 2'd0, 16'h12AB, 32'h01020A0B, 4'b1111};
        vecs[1] = '{1'b0, 2'd2, 16'hFF20, 32'h01200A0B, 4'b1111};
        vecs[2] = '{1'b0, 2'd0, 16'h000F, 32'h01200A0F, 4'b1111};
        vecs[3] = '{1'b0, 2'd3, 16'h007E, 32'h7E200A0F, 4'b1111};
        vecs[4] = '{1'b1, 2'd0, 16'h0005, 32'h00000005, SEEN5};
        vecs[5] = '{1'b0, 2'd1, 16'h0003, 32'h00000305, SEEN6};

        tests = 0; fails = 0; use3 = 1'b0;
        reset_n = 1'b0; wr_valid = 1'b0; wr_mode = 1'b0; wr_index = '0; wr_data = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_values("reset");
        reset_n = 1'b1;

        first_fd = 0; second_fd = 0; sel0_low = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (k == 1) check("wr_ready_after_release", {31'h0, wr_ready4}, 32'h1);
            if (k <= 20 && !digit_sel4[0]) sel0_low++;
            if (frame_done4) begin
                if (first_fd == 0) first_fd = k;
                else begin
                    second_fd = k;
                    break;
                end
            end
        end
        check("first_frame_done_cycle", first_fd, 19);
        check("second_frame_done_cycle", second_fd, 39);
        check("digit0_low_cycles", sel0_low, 3);
        capture_frame();
        check_frame(100, DASHES, 4'b1111, 4);

        prev = DASHES;
        for (int r = 0; r < 6; r++) begin
            do_write(vecs[r].mode, vecs[r].idx, vecs[r].data);
            capture_frame();
            check_partial(r, prev);
            capture_frame();
            check_frame(r, vecs[r].codes, vecs[r].seen, 4);
            prev = vecs[r].codes;
        end

        // Write held across the commit cycle.
        repeat (20) @(posedge clock);
        #1 wr_mode = 1'b0; wr_index = 2'd0; wr_data = 16'h002A; wr_valid = 1'b1;
        @(negedge clock);
        check("race_commit_cycle", {31'h0, frame_done4}, 32'h1);
        check("race_ready_low", {31'h0, wr_ready4}, 32'h0);
        @(negedge clock);
        check("race_ready_high", {31'h0, wr_ready4}, 32'h1);
        @(posedge clock);
        #1 wr_valid = 1'b0;
        capture_frame();
        check_partial(6, prev);
        capture_frame();
        check_frame(6, {prev[31:8], 8'h2A}, SEEN6, 4);

        // Reset while a digit is lit and the shadow is dirty.
        do_write(1'b1, 2'd0, 16'h4321);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (digit_sel4 == 4'hF && n < 50);
        check("found_mid_drive", {28'h0, digit_sel4 != 4'hF}, 32'h1);
        #2 reset_n = 1'b0;
        #1 check_reset_values("async_reset");
        @(negedge clock);
        reset_n = 1'b1;
        capture_frame();
        check_frame(7, DASHES, 4'b1111, 4);
        capture_frame();
        check_frame(8, DASHES, 4'b1111, 4);

        // Three-digit instance: out-of-range index, then a valid write.
        use3 = 1'b1;
        do_write(1'b0, 2'd3, 16'h0005);
        capture_frame();
        check_partial(9, DASHES);
        capture_frame();
        check_frame(9, DASHES, 4'b0111, 3);
        capture_frame();
        check_frame(10, DASHES, 4'b0111, 3);
        do_write(1'b0, 2'd1, 16'h0007);
        capture_frame();
        check_partial(11, DASHES);
        capture_frame();
        check_frame(11, 32'h00100710, 4'b0111, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
